// File: rtl/oets_sort_ctrl.sv
// Odd-even transposition sort engine: LOAD a block of DEPTH signed words, SORT in DEPTH phases, DRAIN in order.
// Optional early exit after two consecutive swap-free phases when OETS_SORT_EARLY_EXIT_EN is defined.
module oets_sort_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic [CW-1:0]           r_phase, w_phase_next;
  logic signed [WIDTH-1:0] r_bank [DEPTH];
  logic signed [WIDTH-1:0] w_even [DEPTH];
  logic signed [WIDTH-1:0] w_odd  [DEPTH];
  logic                    w_in_fire;
  logic                    w_sort_done;

`ifdef OETS_SORT_EARLY_EXIT_EN
  logic [DEPTH/2-1:0]      w_even_swap;
  logic [DEPTH/2-1:0]      w_odd_swap;
  logic                    w_phase_clean;
  logic                    r_prev_clean;
`endif

  genvar gi;

  // Even phase: lanes on pairs (2k, 2k+1)
  generate
    for (gi = 0; gi < DEPTH/2; gi++) begin : g_even
      logic w_swap;
      assign w_swap            = r_bank[2*gi] > r_bank[2*gi+1];
      assign w_even[2*gi]      = w_swap ? r_bank[2*gi+1] : r_bank[2*gi];
      assign w_even[2*gi+1]    = w_swap ? r_bank[2*gi]   : r_bank[2*gi+1];
`ifdef OETS_SORT_EARLY_EXIT_EN
      assign w_even_swap[gi]   = w_swap;
`endif
    end

    // Odd phase: lanes on pairs (2k+1, 2k+2); the two end words pass through
    for (gi = 0; gi < DEPTH/2 - 1; gi++) begin : g_odd
      logic w_swap;
      assign w_swap            = r_bank[2*gi+1] > r_bank[2*gi+2];
      assign w_odd[2*gi+1]     = w_swap ? r_bank[2*gi+2] : r_bank[2*gi+1];
      assign w_odd[2*gi+2]     = w_swap ? r_bank[2*gi+1] : r_bank[2*gi+2];
`ifdef OETS_SORT_EARLY_EXIT_EN
      assign w_odd_swap[gi]    = w_swap;
`endif
    end
  endgenerate

  assign w_odd[0]       = r_bank[0];
  assign w_odd[DEPTH-1] = r_bank[DEPTH-1];

`ifdef OETS_SORT_EARLY_EXIT_EN
  assign w_odd_swap[DEPTH/2-1] = 1'b0;
  assign w_phase_clean = r_phase[0] ? ~|w_odd_swap : ~|w_even_swap;
  assign w_sort_done   = (r_phase == LAST) || (r_prev_clean && w_phase_clean);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_prev_clean <= 1'b0;
    else if (r_state == ST_SORT) r_prev_clean <= w_phase_clean;
    else                         r_prev_clean <= 1'b0;
  end
`else
  assign w_sort_done = (r_phase == LAST);
`endif

  assign w_in_fire = in_valid && (r_state == ST_LOAD);

  // Bank contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_bank[r_cnt[AW-1:0]] <= in_data;
    end else if (r_state == ST_SORT) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= r_phase[0] ? w_odd[i] : w_even[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_phase <= w_phase_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_phase_next = r_phase;
    case (r_state)
      ST_LOAD: begin
        if (in_valid) begin
          if (r_cnt == LAST) begin
            w_state_next = ST_SORT;
            w_cnt_next   = '0;
            w_phase_next = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      ST_SORT: begin
        if (w_sort_done) begin
          w_state_next = ST_DRAIN;
          w_cnt_next   = '0;
          w_phase_next = '0;
        end else begin
          w_phase_next = r_phase + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (r_cnt == LAST) begin
            w_state_next = ST_LOAD;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_next = ST_LOAD;
        w_cnt_next   = '0;
        w_phase_next = '0;
      end
    endcase
  end

  // Handshake outputs decode from registered state only
  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DRAIN);
  assign busy      = (r_state == ST_SORT) || (r_state == ST_DRAIN);
  assign out_data  = (r_state == ST_DRAIN) ? r_bank[r_cnt[AW-1:0]] : '0;
  assign out_last  = (r_state == ST_DRAIN) && (r_cnt == LAST);

endmodule

// File: tb/tb_oets_sort_ctrl.sv
// Directed-vector bench for oets_sort_ctrl (DEPTH=8, WIDTH=32); expectations follow OETS_SORT_EARLY_EXIT_EN.
module tb_oets_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

`ifdef OETS_SORT_EARLY_EXIT_EN
  localparam int SORTED_LAT = 2;
`else
  localparam int SORTED_LAT = 8;
`endif

  oets_sort_ctrl #(.WIDTH(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Feeds 8 words; returns just after the edge of the final handshake
  task automatic load_block(input int w[8], input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < 8 && cyc < 100) begin
      @(negedge clk);
      check("load_busy", {31'b0, busy}, 32'd0);
      if (gaps && ((cyc % 5) == 1 || (cyc % 5) == 4)) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
      end else begin
        in_valid = 1'b1;
        in_data  = w[k];
      end
      if (in_valid && in_ready) k++;
      cyc++;
    end
    if (k < 8) check("load_timeout", k, 8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_after_load", {31'b0, in_ready}, 32'd0);
    check("busy_after_load", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_valid(input int exp_lat);
    int cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("latency", cycles, exp_lat);
  endtask

  task automatic drain_block(input int e[8], input bit bp);
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    int k = 0;
    int cyc = 0;
    while (k < 8 && cyc < 100) begin
      @(negedge clk);
      out_ready = bp ? pat[cyc % 6] : 1'b1;
      check("out_valid", {31'b0, out_valid}, 32'd1);
      check("out_data", out_data, e[k]);
      check("out_last", {31'b0, out_last}, {31'b0, (k == 7)});
      check("in_ready_drain", {31'b0, in_ready}, 32'd0);
      if (out_ready) k++;
      cyc++;
    end
    if (k < 8) check("drain_timeout", k, 8);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int w1[8]  = '{5, -3, 7, 0, -3, 2, 9, -8};
    int e1[8]  = '{-8, -3, -3, 0, 2, 5, 7, 9};
    int w2[8]  = '{32'h7FFFFFFF, 32'h80000000, 0, 32'hFFFFFFFF, 1, 32'h80000000, 32'h7FFFFFFF, 0};
    int e2[8]  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 32'h7FFFFFFF, 32'h7FFFFFFF};
    int up[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int dn[8]  = '{8, 7, 6, 5, 4, 3, 2, 1};
    int mix[8] = '{3, 8, 1, 6, 2, 7, 5, 4};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mixed signed block, contiguous drain
    load_block(w1, 1'b0);
    wait_valid(8);
    drain_block(e1, 1'b0);

    // Signed extremes
    load_block(w2, 1'b0);
    wait_valid(8);
    drain_block(e2, 1'b0);

    // Backpressure on drain
    load_block(w1, 1'b0);
    wait_valid(8);
    drain_block(e1, 1'b1);

    // Input gaps; idle bubbles must not be written into the bank
    load_block(w1, 1'b1);
    wait_valid(8);
    drain_block(e1, 1'b0);

    // Already sorted and reverse sorted
    load_block(up, 1'b0);
    wait_valid(SORTED_LAT);
    drain_block(up, 1'b0);
    load_block(dn, 1'b0);
    wait_valid(8);
    drain_block(up, 1'b0);

    // Reset in the middle of a drain after 3 beats
    load_block(dn, 1'b0);
    wait_valid(8);
    repeat (3) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
    end
    #1;
    out_ready = 1'b0;
    check("mid_drain_data", out_data, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    load_block(mix, 1'b0);
    wait_valid(8);
    drain_block(up, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
